// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU opcodes, arbiter state encoding and request/response records.
package cpu_types_pkg;

    typedef enum logic [3:0] {
        AluSll  = 4'h0,
        AluSrl  = 4'h1,
        AluAnd  = 4'h2,
        AluOr   = 4'h3,
        AluXor  = 4'h4,
        AluNor  = 4'h5,
        AluAdd  = 4'h6,
        AluSub  = 4'h7,
        AluSlt  = 4'h8,
        AluSltu = 4'h9
    } aluop_t;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } arb_state_t;

    typedef struct packed {
        aluop_t      aluop;
        logic [31:0] a;
        logic [31:0] b;
    } alu_req_t;

    typedef struct packed {
        logic [31:0] out;
        logic        negative;
        logic        overflow;
        logic        zero;
        logic        illegal;
    } alu_rsp_t;

    // Legal codes are contiguous from 0, so a range test is enough.
    function automatic logic aluop_legal(logic [3:0] op);
        return op <= 4'h9;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Two-port request/response bundle between the requesters and alu_arbiter.
interface alu_arbiter_if;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][3:0]  req_aluop;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [31:0]      rsp_out;
    logic             rsp_negative;
    logic             rsp_overflow;
    logic             rsp_zero;
    logic             rsp_illegal;
    logic             busy;

    modport master (
        output req_valid, req_aluop, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_out, rsp_negative, rsp_overflow, rsp_zero,
               rsp_illegal, busy
    );

    modport slave (
        input  req_valid, req_aluop, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_out, rsp_negative, rsp_overflow, rsp_zero,
               rsp_illegal, busy
    );

endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU with negative/overflow/zero flags.
module alu
    import cpu_types_pkg::*;
(
    input  aluop_t      aluop_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] out_o,
    output logic        negative_o,
    output logic        overflow_o,
    output logic        zero_o
);

    logic [31:0] sum;
    logic [31:0] diff;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;

    always_comb begin
        out_o      = '0;
        overflow_o = 1'b0;
        case (aluop_i)
            AluSll:  out_o = a_i << b_i[4:0];
            AluSrl:  out_o = a_i >> b_i[4:0];
            AluAnd:  out_o = a_i & b_i;
            AluOr:   out_o = a_i | b_i;
            AluXor:  out_o = a_i ^ b_i;
            AluNor:  out_o = ~(a_i | b_i);
            AluAdd: begin
                out_o      = sum;
                overflow_o = (a_i[31] == b_i[31]) && (sum[31] != a_i[31]);
            end
            AluSub: begin
                out_o      = diff;
                overflow_o = (a_i[31] != b_i[31]) && (diff[31] != a_i[31]);
            end
            AluSlt:  out_o = {31'b0, $signed(a_i) < $signed(b_i)};
            AluSltu: out_o = {31'b0, a_i < b_i};
            default: out_o = '0;
        endcase
    end

    assign negative_o = out_o[31];
    assign zero_o     = (out_o == '0);

endmodule

// File: rtl/alu_rr_pick.sv
// Two-way round-robin picker: a lone requester wins, a contest goes to the port not served last.
module alu_rr_pick (
    input  logic [1:0] req_valid_i,
    input  logic       rr_last_i,
    output logic [1:0] grant_oh_o,
    output logic       grant_idx_o
);

    always_comb begin
        grant_idx_o = 1'b0;
        case (req_valid_i)
            2'b11:   grant_idx_o = ~rr_last_i;
            2'b10:   grant_idx_o = 1'b1;
            default: grant_idx_o = 1'b0;
        endcase
        grant_oh_o = (|req_valid_i) ? (2'b01 << grant_idx_o) : 2'b00;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters.
// Optional ALU_ARB_BYPASS_EN: arbitrate during the response handshake for 2-cycle throughput.
module alu_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned RR_INIT = 0,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned AOP_W   = 4
) (
    input  logic          CLK,
    input  logic          RST,
    alu_arbiter_if.slave  bus
);

    if (DATA_W != 32 || AOP_W != 4 || RR_INIT > 1) begin : g_param_check
        $error("alu_arbiter: only DATA_W=32, AOP_W=4, RR_INIT in {0,1} are supported");
    end

    localparam logic RrLastInit = (RR_INIT == 0) ? 1'b1 : 1'b0;

    arb_state_t state_q, state_d;
    logic       rr_last_q, rr_last_d;
    logic       grant_q, grant_d;
    alu_req_t   req_q, req_d;
    alu_rsp_t   rsp_q, rsp_d;
    logic [1:0] rsp_valid_q, rsp_valid_d;
    logic       busy_q, busy_d;

    logic [1:0]  pick_oh;
    logic        pick_idx;
    logic        arb_en;
    logic        req_hs;
    logic        rsp_hs;
    logic [31:0] alu_out;
    logic        alu_neg;
    logic        alu_ovf;
    logic        alu_zero;

    alu_rr_pick u_pick (
        .req_valid_i (bus.req_valid),
        .rr_last_i   (rr_last_q),
        .grant_oh_o  (pick_oh),
        .grant_idx_o (pick_idx)
    );

    alu u_alu (
        .aluop_i    (req_q.aluop),
        .a_i        (req_q.a),
        .b_i        (req_q.b),
        .out_o      (alu_out),
        .negative_o (alu_neg),
        .overflow_o (alu_ovf),
        .zero_o     (alu_zero)
    );

    assign rsp_hs = (state_q == StResp) && bus.rsp_ready[grant_q];

`ifdef ALU_ARB_BYPASS_EN
    assign arb_en = !RST && ((state_q == StIdle) || rsp_hs);
`else
    assign arb_en = !RST && (state_q == StIdle);
`endif

    assign bus.req_ready = arb_en ? pick_oh : 2'b00;
    assign req_hs        = |bus.req_ready;

    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        grant_d     = grant_q;
        req_d       = req_q;
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;
        busy_d      = busy_q;

        case (state_q)
            StIdle: ;
            StExec: begin
                // Illegal ops must never expose the ALU output or its flags.
                if (aluop_legal(req_q.aluop)) begin
                    rsp_d = '{out: alu_out, negative: alu_neg, overflow: alu_ovf,
                              zero: alu_zero, illegal: 1'b0};
                end else begin
                    rsp_d         = '0;
                    rsp_d.illegal = 1'b1;
                end
                rsp_valid_d = 2'b01 << grant_q;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_hs) begin
                    rsp_valid_d = 2'b00;
                    busy_d      = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Only reachable from StIdle, or from StResp when the bypass is built in.
        if (req_hs) begin
            req_d     = '{aluop: aluop_t'(bus.req_aluop[pick_idx]),
                          a: bus.req_a[pick_idx], b: bus.req_b[pick_idx]};
            grant_d   = pick_idx;
            rr_last_d = pick_idx;
            busy_d    = 1'b1;
            state_d   = StExec;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            rr_last_q   <= RrLastInit;
            grant_q     <= 1'b0;
            req_q       <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 2'b00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            grant_q     <= grant_d;
            req_q       <= req_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_out      = rsp_q.out;
    assign bus.rsp_negative = rsp_q.negative;
    assign bus.rsp_overflow = rsp_q.overflow;
    assign bus.rsp_zero     = rsp_q.zero;
    assign bus.rsp_illegal  = rsp_q.illegal;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; expected gap between accepts follows ALU_ARB_BYPASS_EN.
module tb_alu_arbiter;
    import cpu_types_pkg::*;

`ifdef ALU_ARB_BYPASS_EN
    localparam int ExpGap = 2;
    localparam bit Bypass = 1'b1;
`else
    localparam int ExpGap = 3;
    localparam bit Bypass = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    alu_arbiter_if bus ();

    alu_arbiter #(
        .RR_INIT (0),
        .DATA_W  (32),
        .AOP_W   (4)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.req_ready == 2'b00 && n < 10) begin
            step();
            n++;
        end
        check(tag, 32'(bus.req_ready != 2'b00), 32'd1);
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (bus.rsp_valid == 2'b00 && n < 10) begin
            step();
            n++;
        end
        check(tag, 32'(bus.rsp_valid != 2'b00), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    // Issues one op on port p, waits for its response and leaves the DUT in the response cycle.
    task automatic issue(input int p, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        bus.req_aluop[p] = op;
        bus.req_a[p]     = a;
        bus.req_b[p]     = b;
        bus.req_valid    = 2'b01 << p;
        bus.rsp_ready    = 2'b01 << p;
        #1;
        wait_ready("issue_accept");
        step();
        bus.req_valid = 2'b00;
        #1;
        wait_rsp("issue_rsp");
    endtask

    initial begin
        int acc[$];
        bus.req_valid = '0;
        bus.req_aluop = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '0;
        rst           = 1'b1;
        do_reset();

        // Reset state
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_rsp_out", bus.rsp_out, 32'h0);
        check("rst_flags", 32'({bus.rsp_negative, bus.rsp_overflow, bus.rsp_zero,
                                bus.rsp_illegal}), 32'h0);

        // Fairness: both always valid, first contest goes to port 0
        bus.req_aluop[0] = AluAnd;
        bus.req_a[0]     = 32'hF0F0_F0F0;
        bus.req_b[0]     = 32'h0FF0_0FF0;
        bus.req_aluop[1] = AluOr;
        bus.req_a[1]     = 32'h1234_0000;
        bus.req_b[1]     = 32'h0000_5678;
        bus.req_valid    = 2'b11;
        bus.rsp_ready    = 2'b11;
        #1;
        for (int op = 0; op < 4; op++) begin
            wait_ready("rr_wait_ready");
            check("rr_grant", 32'(bus.req_ready), (op % 2 == 0) ? 32'h1 : 32'h2);
            step();
            wait_rsp("rr_wait_rsp");
            check("rr_rsp_valid", 32'(bus.rsp_valid), (op % 2 == 0) ? 32'h1 : 32'h2);
            check("rr_rsp_out", bus.rsp_out, (op % 2 == 0) ? 32'h00F0_00F0 : 32'h1234_5678);
            if (op == 3) begin
                bus.req_valid = 2'b00;
                #1;
            end
        end
        step();
        check("rr_idle_busy", 32'(bus.busy), 32'h0);

        // Stalled response on port 1, port 0 waits
        bus.rsp_ready    = 2'b00;
        bus.req_aluop[1] = AluSub;
        bus.req_a[1]     = 32'd5;
        bus.req_b[1]     = 32'd5;
        bus.req_valid    = 2'b10;
        #1;
        check("stall_accept", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_aluop[0] = AluXor;
        bus.req_a[0]     = 32'hFF00_FF00;
        bus.req_b[0]     = 32'h0FF0_0FF0;
        bus.req_valid    = 2'b01;
        #1;
        check("stall_exec_ready", 32'(bus.req_ready), 32'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            check("stall_rsp_valid", 32'(bus.rsp_valid), 32'h2);
            check("stall_rsp_out", bus.rsp_out, 32'h0);
            check("stall_zero", 32'(bus.rsp_zero), 32'h1);
            check("stall_req_ready", 32'(bus.req_ready), 32'h0);
            bus.rsp_ready = (i == 2) ? 2'b01 : 2'b00;
            step();
        end
        bus.rsp_ready = 2'b10;
        #1;
        check("stall_hold_valid", 32'(bus.rsp_valid), 32'h2);
        check("stall_hs_ready", 32'(bus.req_ready), Bypass ? 32'h1 : 32'h0);
        step();
        if (!Bypass) begin
            check("stall_idle_ready", 32'(bus.req_ready), 32'h1);
            step();
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b11;
        #1;
        wait_rsp("stall_p0_rsp");
        check("stall_p0_valid", 32'(bus.rsp_valid), 32'h1);
        check("stall_p0_out", bus.rsp_out, 32'hF0F0_F0F0);
        check("stall_p0_neg", 32'(bus.rsp_negative), 32'h1);
        step();

        // Illegal opcode
        issue(0, 4'hF, 32'hDEAD_BEEF, 32'h1);
        check("ill_out", bus.rsp_out, 32'h0);
        check("ill_flag", 32'(bus.rsp_illegal), 32'h1);
        check("ill_nvz", 32'({bus.rsp_negative, bus.rsp_overflow, bus.rsp_zero}), 32'h0);
        step();

        // Shift: overflow stays 0 outside ADD/SUB
        issue(1, AluSll, 32'h1, 32'd31);
        check("sll_out", bus.rsp_out, 32'h8000_0000);
        check("sll_flags", 32'({bus.rsp_negative, bus.rsp_overflow, bus.rsp_zero,
                                bus.rsp_illegal}), 32'h8);
        step();

        issue(1, AluSlt, 32'hFFFF_FFFF, 32'h1);
        check("slt_out", bus.rsp_out, 32'h1);
        step();

        // Latency and flags of a signed-overflowing ADD
        do_reset();
        bus.req_aluop[0] = AluAdd;
        bus.req_a[0]     = 32'h7FFF_FFFF;
        bus.req_b[0]     = 32'h1;
        bus.req_valid    = 2'b01;
        bus.rsp_ready    = 2'b00;
        #1;
        check("add_accept", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = 2'b00;
        #1;
        check("add_exec_busy", 32'(bus.busy), 32'h1);
        check("add_exec_valid", 32'(bus.rsp_valid), 32'h0);
        step();
        check("add_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check("add_out", bus.rsp_out, 32'h8000_0000);
        check("add_ovf", 32'(bus.rsp_overflow), 32'h1);
        check("add_neg", 32'(bus.rsp_negative), 32'h1);
        check("add_zero", 32'(bus.rsp_zero), 32'h0);
        bus.rsp_ready = 2'b01;
        step();
        check("add_done_valid", 32'(bus.rsp_valid), 32'h0);
        check("add_done_busy", 32'(bus.busy), 32'h0);

        // Reset during EXEC drops the operation
        bus.req_a[0]  = 32'h1;
        bus.req_valid = 2'b01;
        #1;
        check("rexec_accept", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = 2'b00;
        check("rexec_busy", 32'(bus.busy), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rexec_state", 32'(dut.state_q), 32'(StIdle));
        check("rexec_valid", 32'(bus.rsp_valid), 32'h0);
        check("rexec_busy0", 32'(bus.busy), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rexec_no_rsp", 32'(bus.rsp_valid), 32'h0);
        end

        // Throughput with port 0 always valid and always ready
        bus.req_valid = 2'b01;
        bus.rsp_ready = 2'b01;
        #1;
        for (int c = 0; c < 13; c++) begin
            if (bus.req_ready[0]) acc.push_back(cyc);
            step();
        end
        bus.req_valid = 2'b00;
        check("tput_count", 32'(acc.size() >= 4), 32'h1);
        for (int k = 1; k < acc.size(); k++) begin
            check("tput_gap", 32'(acc[k] - acc[k-1]), 32'(ExpGap));
        end
        for (int n = 0; n < 10 && bus.busy; n++) step();
        check("tput_drain", 32'(bus.busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
